// File: rtl/drv_audio_fifo_tx.sv
// ---------------------------------------------------------------------------
// drv_audio_fifo_tx
//
// Stereo playback sample buffer sitting directly in front of the WM8731 codec
// driver. The audio source pushes L/R frames over a valid/ready handshake. The
// codec driver sees a registered frame on o_dat and strobes i_ack once it has
// consumed that frame, which advances the buffer to the next frame.
//
// After reset or a clear, the buffer sits in PRIME until p_prime frames are
// stored. It then plays in RUN. An ack while RUN with nothing stored is an
// underrun: o_uflow is set (sticky) and the buffer returns to PRIME to re-prime.
//
// Build option:
//   DRV_AUDIO_FIFO_HOLD_EN - when defined, in PRIME and on underrun, o_dat
//                            repeats the last frame instead of going silent.
//                            Clear and reset always force silence.
//
// Ports:
//   i_clk    system clock
//   i_rst    asynchronous reset, active low
//   i_clr    synchronous flush, highest priority
//   i_dat    producer frame, [0]=left, [1]=right
//   i_vld    producer frame valid
//   o_rdy    buffer can accept a frame (not full)
//   o_dat    registered frame presented to the codec driver
//   i_ack    driver strobe: o_dat consumed, advance
//   o_lvl    frames stored, 0..p_depth
//   o_run    1 = RUN, 0 = PRIME
//   o_uflow  sticky underrun flag
// ---------------------------------------------------------------------------
module drv_audio_fifo_tx #(
  parameter int p_width = 16,
  parameter int p_depth = 16,
  parameter int p_prime = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_clr,
  input  logic [1:0][p_width-1:0]         i_dat,
  input  logic                            i_vld,
  output logic                            o_rdy,
  output logic [1:0][p_width-1:0]         o_dat,
  input  logic                            i_ack,
  output logic [$clog2(p_depth):0]        o_lvl,
  output logic                            o_run,
  output logic                            o_uflow
);

  localparam int AW = $clog2(p_depth);
  localparam int LW = AW + 1;

  localparam logic [0:0] ST_PRIME = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [1:0][p_width-1:0] mem [p_depth];

  logic [LW-1:0]           wr_ptr;
  logic [LW-1:0]           rd_ptr;
  logic [LW-1:0]           lvl;
  logic [LW-1:0]           lvl_next;
  logic [0:0]              state;
  logic [1:0][p_width-1:0] dat_q;
  logic [1:0][p_width-1:0] idle_dat;
  logic                    uflow_q;

  logic wr_en;
  logic ack_run;
  logic pop;
  logic underrun;
  logic prime_done;

  // Pointers carry one extra bit, so their plain difference is the fill level
  // and it stays correct across wrap-around.
  assign lvl   = wr_ptr - rd_ptr;
  assign o_lvl = lvl;
  assign o_rdy = (lvl != LW'(p_depth));

  assign wr_en    = i_vld & o_rdy;
  assign ack_run  = i_ack & (state == ST_RUN);
  assign pop      = ack_run & (lvl != '0);
  // An ack against an empty buffer is an underrun, even if a write lands in
  // the same cycle. There is no bypass path; the written frame is just stored.
  assign underrun = ack_run & (lvl == '0);

  assign lvl_next   = lvl + LW'(wr_en) - LW'(pop);
  assign prime_done = (state == ST_PRIME) & (lvl_next >= LW'(p_prime));

`ifdef DRV_AUDIO_FIFO_HOLD_EN
  assign idle_dat = dat_q;
`else
  assign idle_dat = '0;
`endif

  // Frame storage has no reset. Its contents are only observable through the
  // pointers, and those are reset. A clear discards a same-cycle write.
  always_ff @(posedge i_clk) begin
    if (wr_en && !i_clr) begin
      mem[wr_ptr[AW-1:0]] <= i_dat;
    end
  end

  // Pointers, state, the presented frame and the sticky flag. o_dat only
  // moves on an ack. It takes the head frame on a real pop. Otherwise it takes
  // the idle frame (silence, or the last frame when hold is enabled).
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      state   <= ST_PRIME;
      dat_q   <= '0;
      uflow_q <= 1'b0;
    end else if (i_clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      state   <= ST_PRIME;
      dat_q   <= '0;
      uflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + LW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + LW'(1);
      end
      if (i_ack) begin
        dat_q <= pop ? mem[rd_ptr[AW-1:0]] : idle_dat;
      end
      if (underrun) begin
        uflow_q <= 1'b1;
        state   <= ST_PRIME;
      end else if (prime_done) begin
        state   <= ST_RUN;
      end
    end
  end

  assign o_dat   = dat_q;
  assign o_run   = (state == ST_RUN);
  assign o_uflow = uflow_q;

endmodule

// File: tb/tb_drv_audio_fifo_tx.sv
// ---------------------------------------------------------------------------
// tb_drv_audio_fifo_tx
//
// Self-checking bench for drv_audio_fifo_tx. A queue-based model tracks the
// stored frames, the play state, the presented frame and the underrun flag.
// The outputs are compared against this model on every cycle. Directed
// sequences also pin specific literal values. A randomized phase follows, and
// the run ends with an asynchronous reset in the middle of the stream.
// Honours DRV_AUDIO_FIFO_HOLD_EN so it can be built for either variant.
// ---------------------------------------------------------------------------
module tb_drv_audio_fifo_tx;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int PRIME = 8;

`ifdef DRV_AUDIO_FIFO_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic                  clk;
  logic                  rst;
  logic                  clr;
  logic [1:0][WIDTH-1:0] dat_in;
  logic                  vld;
  logic                  rdy;
  logic [1:0][WIDTH-1:0] dat_out;
  logic                  ack;
  logic [4:0]            lvl;
  logic                  run;
  logic                  uflow;

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model state.
  logic [31:0] q[$];
  bit          m_run;
  logic [31:0] m_dat;
  bit          m_uf;

  drv_audio_fifo_tx #(
    .p_width(WIDTH),
    .p_depth(DEPTH),
    .p_prime(PRIME)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clr  (clr),
    .i_dat  (dat_in),
    .i_vld  (vld),
    .o_rdy  (rdy),
    .o_dat  (dat_out),
    .i_ack  (ack),
    .o_lvl  (lvl),
    .o_run  (run),
    .o_uflow(uflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_run = 1'b0;
    m_dat = '0;
    m_uf  = 1'b0;
  endtask

  // One clock edge of the model, computed from the buffer rules directly.
  task automatic model_update(input bit v, input logic [31:0] d, input bit a, input bit c);
    bit wr;
    bit was_prime;
    wr = v && (q.size() != DEPTH);
    if (c) begin
      model_reset();
      return;
    end
    was_prime = !m_run;
    if (a) begin
      if (was_prime) begin
        m_dat = HOLD ? m_dat : 32'h0;
      end else if (q.size() != 0) begin
        m_dat = q.pop_front();
      end else begin
        m_dat = HOLD ? m_dat : 32'h0;
        m_uf  = 1'b1;
        m_run = 1'b0;
      end
    end
    if (wr) q.push_back(d);
    if (was_prime && q.size() >= PRIME) m_run = 1'b1;
  endtask

  task automatic check_output();
    check("o_dat",   dat_out, m_dat);
    check("o_lvl",   32'(lvl), 32'(q.size()));
    check("o_run",   32'(run), 32'(m_run));
    check("o_uflow", 32'(uflow), 32'(m_uf));
    check("o_rdy",   32'(rdy), 32'(q.size() != DEPTH));
  endtask

  // Inputs are driven at the falling edge and the model advances at the
  // rising edge. Outputs are compared at the next falling edge.
  task automatic apply_stimulus(input bit v, input logic [31:0] d, input bit a, input bit c);
    vld    = v;
    dat_in = d;
    ack    = a;
    clr    = c;
    @(posedge clk);
    model_update(v, d, a, c);
    @(negedge clk);
    check_output();
  endtask

  function automatic logic [31:0] frame(input int n);
    return {16'(32'h8000 + n), 16'(n)};
  endfunction

  initial begin
    rst    = 1'b0;
    clr    = 1'b0;
    vld    = 1'b0;
    ack    = 1'b0;
    dat_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset o_lvl", 32'(lvl), 32'h0);
    check("reset o_dat", dat_out, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check_output();

    // Idle acks in PRIME: output stays silent.
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    check("prime acks o_dat", dat_out, 32'h0);
    check("prime acks o_run", 32'(run), 32'h0);

    // Prime with 8 frames.
    for (int n = 1; n <= PRIME; n++) begin
      apply_stimulus(1'b1, frame(n), 1'b0, 1'b0);
      if (n == PRIME - 1) check("run before prime", 32'(run), 32'h0);
    end
    check("run after prime", 32'(run), 32'h1);
    check("lvl after prime", 32'(lvl), 32'd8);

    // Eight acks deliver frames in order, then a ninth ack underruns.
    for (int n = 1; n <= PRIME; n++) begin
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
      check("ordered o_dat", dat_out, frame(n));
    end
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    check("underrun uflow", 32'(uflow), 32'h1);
    check("underrun run", 32'(run), 32'h0);
    check("underrun o_dat", dat_out, HOLD ? 32'h8008_0008 : 32'h0);

    // Clear, then fill completely.
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
    check("clr uflow", 32'(uflow), 32'h0);
    for (int n = 1; n <= DEPTH; n++) apply_stimulus(1'b1, frame(n), 1'b0, 1'b0);
    check("full rdy", 32'(rdy), 32'h0);
    check("full lvl", 32'(lvl), 32'd16);
    // The 17th frame is held off while full, even with a same-cycle ack.
    apply_stimulus(1'b1, frame(17), 1'b1, 1'b0);
    check("full+ack lvl", 32'(lvl), 32'd15);
    check("full+ack o_dat", dat_out, frame(1));
    apply_stimulus(1'b1, frame(17), 1'b0, 1'b0);
    check("17th accepted lvl", 32'(lvl), 32'd16);
    for (int n = 2; n <= 17; n++) apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    check("17th frame out", dat_out, 32'h8011_0011);
    check("drained lvl", 32'(lvl), 32'h0);
    check("drained run", 32'(run), 32'h1);

    // Empty in RUN, with a write and an ack together.
    apply_stimulus(1'b1, frame(40), 1'b1, 1'b0);
    check("wr+ack empty uflow", 32'(uflow), 32'h1);
    check("wr+ack empty lvl", 32'(lvl), 32'h1);

    // Clear with a write and an ack pending at level 5.
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
    for (int n = 1; n <= 5; n++) apply_stimulus(1'b1, frame(n), 1'b0, 1'b0);
    apply_stimulus(1'b1, frame(6), 1'b1, 1'b1);
    check("clr lvl", 32'(lvl), 32'h0);
    check("clr o_dat", dat_out, 32'h0);
    check("clr run", 32'(run), 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus($urandom_range(0, 99) < 55, $urandom(),
                     $urandom_range(0, 99) < 45, $urandom_range(0, 299) == 0);
    end

    // Asynchronous reset in the middle of a cycle.
    for (int n = 1; n <= 10; n++) apply_stimulus(1'b1, frame(n + 60), n > 8, 1'b0);
    vld = 1'b0;
    ack = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async rst lvl", 32'(lvl), 32'h0);
    check("async rst run", 32'(run), 32'h0);
    check("async rst o_dat", dat_out, 32'h0);
    check("async rst uflow", 32'(uflow), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output();
    for (int n = 1; n <= PRIME; n++) apply_stimulus(1'b1, frame(n), 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    check("post-reset first frame", dat_out, 32'h8001_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
